// File: rtl/button_uart_tx.sv
// Button event to UART bridge: encodes debounced press/release pulses as 'D'/'U',
// queues them in a small FIFO and transmits each as an 8N1 frame.
module button_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       down_i,
  input  logic       up_i,
  output logic       tx_o,
  output logic       busy_o,
  output logic       overflow_o,
  output logic [7:0] press_count_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   FIFO_FULL = (AW + 1)'(FIFO_DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  localparam logic [7:0] CHAR_DOWN = 8'h44;
  localparam logic [7:0] CHAR_UP   = 8'h55;

  logic [7:0]    fifo_mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic [AW:0]   count_s;

  logic          push_req_s;
  logic          push_ok_s;
  logic          pop_s;
  logic [7:0]    push_data_s;

  logic [1:0]    state_r;
  logic [1:0]    state_s;
  logic [7:0]    shift_r;
  logic [7:0]    shift_s;
  logic [CW-1:0] bit_cnt_r;
  logic [CW-1:0] bit_cnt_s;
  logic [2:0]    bit_idx_r;
  logic [2:0]    bit_idx_s;
  logic          tx_r;
  logic          tx_s;
  logic          busy_r;
  logic          overflow_r;
  logic [7:0]    press_count_r;

  // Event encode and FIFO handshake; a simultaneous press/release keeps only the press.
  always_comb begin
    push_req_s  = down_i | up_i;
    push_data_s = down_i ? CHAR_DOWN : CHAR_UP;
    pop_s       = (state_r == IDLE) && (count_r != (AW + 1)'(0));
    push_ok_s   = push_req_s && ((count_r < FIFO_FULL) || pop_s);
    case ({push_ok_s, pop_s})
      2'b10:   count_s = count_r + (AW + 1)'(1);
      2'b01:   count_s = count_r - (AW + 1)'(1);
      default: count_s = count_r;
    endcase
  end

  // FIFO storage and pointers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_r[i] <= 8'h00;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) begin
        fifo_mem_r[wr_ptr_r] <= push_data_s;
        wr_ptr_r             <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r <= count_s;
    end
  end

  // Transmit FSM next-state; tx_s is the value the output flop takes at the next edge.
  always_comb begin
    state_s   = state_r;
    shift_s   = shift_r;
    bit_cnt_s = bit_cnt_r;
    bit_idx_s = bit_idx_r;
    tx_s      = tx_r;
    case (state_r)
      IDLE: begin
        if (pop_s) begin
          state_s   = START;
          shift_s   = fifo_mem_r[rd_ptr_r];
          bit_cnt_s = '0;
          tx_s      = 1'b0;
        end else begin
          tx_s = 1'b1;
        end
      end
      START: begin
        if (bit_cnt_r == BIT_LAST) begin
          state_s   = DATA;
          bit_cnt_s = '0;
          bit_idx_s = 3'd0;
          tx_s      = shift_r[0];
        end else begin
          bit_cnt_s = bit_cnt_r + CW'(1);
        end
      end
      DATA: begin
        if (bit_cnt_r == BIT_LAST) begin
          bit_cnt_s = '0;
          if (bit_idx_r == 3'd7) begin
            state_s = STOP;
            tx_s    = 1'b1;
          end else begin
            bit_idx_s = bit_idx_r + 3'd1;
            shift_s   = {1'b0, shift_r[7:1]};
            tx_s      = shift_r[1];
          end
        end else begin
          bit_cnt_s = bit_cnt_r + CW'(1);
        end
      end
      STOP: begin
        if (bit_cnt_r == BIT_LAST) begin
          state_s   = IDLE;
          bit_cnt_s = '0;
          tx_s      = 1'b1;
        end else begin
          bit_cnt_s = bit_cnt_r + CW'(1);
        end
      end
      default: begin
        state_s   = IDLE;
        bit_cnt_s = '0;
        bit_idx_s = 3'd0;
        tx_s      = 1'b1;
      end
    endcase
  end

  // FSM registers and registered status outputs.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r       <= IDLE;
      shift_r       <= 8'h00;
      bit_cnt_r     <= '0;
      bit_idx_r     <= 3'd0;
      tx_r          <= 1'b1;
      busy_r        <= 1'b0;
      overflow_r    <= 1'b0;
      press_count_r <= 8'd0;
    end else begin
      state_r   <= state_s;
      shift_r   <= shift_s;
      bit_cnt_r <= bit_cnt_s;
      bit_idx_r <= bit_idx_s;
      tx_r      <= tx_s;
      // Busy tracks the post-edge state so it drops together with the return to IDLE.
      busy_r    <= (state_s != IDLE) || (count_s != (AW + 1)'(0));
      if (push_req_s && !push_ok_s) begin
        overflow_r <= 1'b1;
      end
      if (down_i) begin
        press_count_r <= press_count_r + 8'd1;
      end
    end
  end

  assign tx_o          = tx_r;
  assign busy_o        = busy_r;
  assign overflow_o    = overflow_r;
  assign press_count_o = press_count_r;

endmodule

// File: tb/tb_button_uart_tx.sv
// Randomised and directed scoreboard bench for button_uart_tx with a
// transaction-level model of the FIFO and frame timing.
module tb_button_uart_tx;
  localparam int C     = 4;
  localparam int D     = 4;
  localparam int FRAME = 10 * C;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       down = 1'b0;
  logic       up = 1'b0;
  logic       tx;
  logic       busy;
  logic       ovf;
  logic [7:0] pc;

  button_uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .down_i(down), .up_i(up),
    .tx_o(tx), .busy_o(busy), .overflow_o(ovf), .press_count_o(pc)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int frames_seen = 0;

  // Scoreboard: bytes accepted into the FIFO and the edges at which frames must start.
  logic [7:0] exp_q[$];
  int         fall_q[$];
  int         fall_log[$];

  // Reference model state: entries waiting, first edge the transmitter is free again.
  int         mdl_cnt = 0;
  int         free_at = 0;
  logic [7:0] mdl_pc = 8'd0;
  logic       mdl_ovf = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // UART receiver monitor, sampling each bit in mid-period on the falling clock edge.
  initial begin
    int         mon_s;
    logic       mon_active;
    logic       prev_tx;
    logic [7:0] rx;
    mon_active = 1'b0;
    prev_tx    = 1'b1;
    mon_s      = 0;
    rx         = 8'h00;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        mon_active = 1'b0;
        prev_tx    = 1'b1;
      end else begin
        if (!mon_active) begin
          if (prev_tx && !tx) begin
            mon_active = 1'b1;
            mon_s      = 0;
            frames_seen++;
            fall_log.push_back(cyc);
            if (fall_q.size() == 0) check("unexpected_frame_start", cyc, -1);
            else check("frame_start_cycle", cyc, fall_q.pop_front());
          end
        end else begin
          mon_s++;
          if (mon_s == C / 2) begin
            check("start_bit", int'(tx), 0);
          end else if (mon_s < 9 * C && (mon_s % C) == C / 2) begin
            rx[mon_s / C - 1] = tx;
          end else if (mon_s == 9 * C + C / 2) begin
            check("stop_bit", int'(tx), 1);
            if (exp_q.size() == 0) check("unexpected_frame_byte", int'(rx), -1);
            else check("frame_byte", int'(rx), int'(exp_q.pop_front()));
            mon_active = 1'b0;
          end
        end
        prev_tx = tx;
      end
    end
  end

  // One clock cycle of stimulus, with the model advanced for the same edge.
  task automatic step(input logic d, input logic u);
    int n;
    bit req;
    bit pop;
    bit acc;
    n    = cyc + 1;
    down = d;
    up   = u;
    req  = d | u;
    pop  = (n >= free_at) && (mdl_cnt > 0);
    if (pop) begin
      free_at = n + FRAME + 1;
      fall_q.push_back(n);
    end
    acc = req && ((mdl_cnt < D) || pop);
    if (acc) exp_q.push_back(d ? 8'h44 : 8'h55);
    if (req && !acc) mdl_ovf = 1'b1;
    if (d) mdl_pc = mdl_pc + 8'd1;
    mdl_cnt = mdl_cnt - int'(pop) + int'(acc);
    @(posedge clk);
    #1;
    down = 1'b0;
    up   = 1'b0;
    check("busy", int'(busy), int'(mdl_cnt != 0 || n + 1 < free_at));
    check("press_count", int'(pc), int'(mdl_pc));
    check("overflow", int'(ovf), int'(mdl_ovf));
  endtask

  task automatic apply_reset(input int hold);
    reset_n = 1'b0;
    exp_q.delete();
    fall_q.delete();
    mdl_cnt = 0;
    free_at = 0;
    mdl_pc  = 8'd0;
    mdl_ovf = 1'b0;
    #1;
    check("reset_tx_immediate", int'(tx), 1);
    repeat (hold) @(posedge clk);
    #1;
    check("reset_tx", int'(tx), 1);
    check("reset_busy", int'(busy), 0);
    check("reset_overflow", int'(ovf), 0);
    check("reset_press_count", int'(pc), 0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic drain(input int budget);
    int i;
    i = 0;
    while ((exp_q.size() != 0 || busy) && i < budget) begin
      step(1'b0, 1'b0);
      i++;
    end
    check("drain_done", exp_q.size() + int'(busy), 0);
  endtask

  initial begin
    #(2_000_000);
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int f0;
    int k;
    int r;
    reset_n = 1'b1;
    #3;
    apply_reset(5);

    // Single press: frame starts one edge after the push, busy clears 41 cycles later.
    f0 = frames_seen;
    step(1'b1, 1'b0);
    k = cyc;
    check("tx_idle_at_push", int'(tx), 1);
    step(1'b0, 1'b0);
    check("tx_fall_after_pop", int'(tx), 0);
    while (cyc < k + FRAME) step(1'b0, 1'b0);
    check("busy_end_of_stop", int'(busy), 1);
    step(1'b0, 1'b0);
    check("busy_after_frame", int'(busy), 0);
    drain(100);
    check("single_frames", frames_seen - f0, 1);
    check("single_press_count", int'(pc), 1);

    // Press then release two cycles apart: two frames, one idle cycle apart.
    f0 = frames_seen;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    drain(200);
    check("pair_frames", frames_seen - f0, 2);
    check("pair_gap", fall_log[fall_log.size() - 1] - fall_log[fall_log.size() - 2], FRAME + 1);

    // Overflow: six consecutive presses, one dropped.
    apply_reset(2);
    f0 = frames_seen;
    repeat (6) step(1'b1, 1'b0);
    check("overflow_set", int'(ovf), 1);
    drain(400);
    check("overflow_frames", frames_seen - f0, 5);
    check("overflow_sticky", int'(ovf), 1);
    check("overflow_press_count", int'(pc), 6);

    // Simultaneous press and release.
    apply_reset(2);
    f0 = frames_seen;
    step(1'b1, 1'b1);
    drain(100);
    check("both_frames", frames_seen - f0, 1);
    check("both_overflow", int'(ovf), 0);
    check("both_press_count", int'(pc), 1);

    // Reset in the middle of data bit 3 with more entries queued.
    apply_reset(2);
    step(1'b1, 1'b0);
    k = cyc;
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    while (cyc < k + 1 + C + 3 * C + 1) step(1'b0, 1'b0);
    check("tx_data_bit3", int'(tx), 0);
    apply_reset(2);
    f0 = frames_seen;
    repeat (60) step(1'b0, 1'b0);
    check("no_frame_after_reset", frames_seen - f0, 0);
    check("tx_idle_after_reset", int'(tx), 1);
    step(1'b0, 1'b1);
    drain(100);
    check("frame_after_reset", frames_seen - f0, 1);

    // Random traffic: a sparse phase, then a dense one that overflows and wraps the counter.
    apply_reset(2);
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 999));
      step(r < 15, r >= 10 && r < 25);
    end
    drain(500);
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      step(r < 12, r >= 8 && r < 20);
    end
    drain(2000);
    check("random_queue_empty", fall_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/button_uart_tx.md
# button_uart_tx

Downstream consumer of the debounced push-button stage in the UART test design. Converts each single-cycle press/release event into an ASCII character ('D' = 0x44 for press, 'U' = 0x55 for release), buffers events in a small FIFO, and serializes them on a UART 8N1 transmit line. It also keeps a press counter and a sticky overflow flag for bring-up visibility on the board.

## Interface
Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); legal range >= 2
- FIFO_DEPTH, 4, event FIFO entries; power of two, >= 2

Ports:
- clk_i  input  1  sole clock; all logic is on its rising edge
- reset_n_i  input  1  reset, asynchronous assert, active-low
- down_i  input  1  single-cycle pulse, debounced button press
- up_i  input  1  single-cycle pulse, debounced button release
- tx_o  output  1  UART serial output; idle high
- busy_o  output  1  high while the FIFO is non-empty or a frame is in flight
- overflow_o  output  1  sticky; set when an event is dropped because the FIFO is full
- press_count_o  output  8  count of down_i pulses seen, accepted or dropped

## Operation
- Reset, while reset_n_i is low: tx_o=1, busy_o=0, overflow_o=0, press_count_o=0, FIFO empty, FSM in IDLE. Applies immediately on assertion and aborts any frame mid-bit.
- Event encode:
  - down_i=1 pushes 0x44.
  - up_i=1 pushes 0x55.
  - Both high in the same cycle pushes 0x44 only. The 'U' is discarded and overflow_o is not set.
- FIFO push:
  - A push is accepted if count < FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the event is dropped and overflow_o is set to 1 until reset.
  - FIFO order is strict first-in, first-out.
- press_count_o increments on every down_i=1, including dropped events. It wraps 255 -> 0.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if the FIFO is non-empty, pop the head into the shift register, drive tx_o=0, and go to START. Otherwise tx_o=1.
  - START: hold tx_o=0 for CLKS_PER_BIT cycles, then go to DATA with tx_o=bit0.
  - DATA: shift 8 bits LSB first, each for CLKS_PER_BIT cycles. After bit7, go to STOP with tx_o=1.
  - STOP: hold tx_o=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Bit-period counter:
  - Width is $clog2(CLKS_PER_BIT).
  - It counts 0..CLKS_PER_BIT-1 and reloads 0 on every state or bit change.
- Bit index counter is 3 bits and is used in DATA only.
- tx_o is driven directly from a flop, with no combinational path to the output.
- busy_o = (state != IDLE) | (FIFO count != 0), registered.

## Timing
- Event sampled high at edge k: FIFO write at edge k. If the FSM is idle, the pop happens at edge k+1, so tx_o falls after edge k+1.
- Frame length is exactly 10*CLKS_PER_BIT cycles from the tx_o fall to the end of STOP.
- Back-to-back frames: the FSM spends exactly one cycle in IDLE with tx_o=1 between frames. Total period is 10*CLKS_PER_BIT+1 cycles.
- A push and a pop in the same cycle with the FIFO full is accepted; count is unchanged.
- A push and a pop in the same cycle with the FIFO empty is not possible. The pop uses the registered count, so the new entry is popped next cycle.
- overflow_o rises the cycle after the dropped event's edge.
- press_count_o updates the cycle after the edge that sampled down_i.
- Reset deassertion is synchronized by the caller. The first push is possible at the first edge with reset_n_i high.

## Test plan
- Reset: hold reset_n_i low 5 cycles with CLKS_PER_BIT=4 -> tx_o=1, busy_o=0, overflow_o=0, press_count_o=0.
- Single press: one down_i pulse at edge k, CLKS_PER_BIT=4.
  - Required: tx_o low from edge k+1 for 4 cycles.
  - Then bits 0,0,1,0,0,0,1,0 (0x44 LSB first), 4 cycles each.
  - Then high 4 cycles; busy_o low after 41 cycles; press_count_o=1.
- Press then release 2 cycles apart -> two frames 0x44 then 0x55, separated by exactly one idle-high cycle.
- Overflow: FIFO_DEPTH=4; 6 down_i pulses on consecutive cycles while the first frame is in flight.
  - Required: 5 'D' frames (1 in flight + 4 buffered), 1 dropped.
  - overflow_o=1 and remains 1; press_count_o=6.
- Simultaneous down_i=up_i=1 -> exactly one 0x44 frame; overflow_o stays 0; press_count_o=1.
- Mid-frame reset: assert reset_n_i during DATA bit 3 -> tx_o=1 immediately, FIFO flushed.
  - After release: no frame is emitted until a new event arrives.
